btc_dec_spc_sort: RTL and testbench

//  Upstream stage of the SPC soft decoder. Consumes one bit metric per cycle of a row/column codeword.

---
 rtl/btc_dec_spc_sort_pkg.sv | 21 ++
 rtl/btc_dec_spc_min2_update.sv | 27 ++
 rtl/btc_dec_spc_sort.sv | 184 ++++++++++++++++++
 tb/tb_btc_dec_spc_sort.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/btc_dec_spc_sort_pkg.sv
// btc_dec_spc_sort_pkg: shared BTC decoder types, code-length helper and Lapri constants
package btc_dec_spc_sort_pkg;
  localparam int cEXTR_W    = 5;
  localparam int cBIT_IDX_W = 6;
  typedef logic [cEXTR_W-1:0]        extr_t;
  typedef logic signed [cEXTR_W:0]   extr_p1_t;
  typedef logic [cBIT_IDX_W-1:0]     bit_idx_t;
  typedef logic [cBIT_IDX_W:0]       code_len_t;
  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
    logic mask;
  } strb_t;
  typedef enum logic [1:0] {cCODE_8, cCODE_16, cCODE_32, cCODE_64} btc_code_mode_t;
  localparam extr_t cEXTR_MAX = extr_t'((1 << (cEXTR_W-1)) - 1);
  function automatic code_len_t get_code_bits(btc_code_mode_t m);
    return code_len_t'(8) << m;
  endfunction
endpackage

// File: rtl/btc_dec_spc_min2_update.sv
// btc_dec_spc_min2_update: folds one new magnitude into the running min0/min1/index/sign-product
module btc_dec_spc_min2_update
  import btc_dec_spc_sort_pkg::*;
(
  input  logic     ifirst,
  input  logic     isign,
  input  extr_t    imag,
  input  bit_idx_t iidx,
  input  extr_t    imin0,
  input  extr_t    imin1,
  input  bit_idx_t imin0_idx,
  input  logic     isign_acc,
  output extr_t    omin0,
  output extr_t    omin1,
  output bit_idx_t omin0_idx,
  output logic     osign
);
  logic lt0, lt1;
  always_comb begin
    lt0       = imag < imin0;
    lt1       = imag < imin1;
    omin0     = (ifirst | lt0) ? imag : imin0;
    omin1     = ifirst ? cEXTR_MAX : lt0 ? imin0 : lt1 ? imag : imin1;
    omin0_idx = (ifirst | lt0) ? iidx : imin0_idx;
    osign     = ifirst ? isign : isign_acc ^ isign;
  end
endmodule

// File: rtl/btc_dec_spc_sort.sv
// btc_dec_spc_sort: forms saturated Lapri per bit, writes it to ping-pong RAM and sorts min0/min1 per codeword
module btc_dec_spc_sort
  import btc_dec_spc_sort_pkg::*;
#(
  parameter int pLLR_W  = 5,
  parameter int pEXTR_W = cEXTR_W
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  btc_code_mode_t    imode,
  input  logic              ival,
  input  strb_t             istrb,
  input  logic [pLLR_W-1:0] iLLR,
  input  extr_t             iLextr,
  input  logic              iuse_extr,
  output logic              oLapri_write,
  output logic              oLapri_wptr,
  output bit_idx_t          oLapri_waddr,
  output extr_t             oLapri_wdat,
  output logic              oval,
  output strb_t             ostrb,
  output logic              oLapri_ptr,
  output logic              oprod_sign,
  output extr_t             omin0,
  output bit_idx_t          omin0_idx,
  output extr_t             omin1,
  output logic              oerr
);
  typedef enum logic {IDLE, ACC} state_t;

  extr_p1_t         llr_x, extr_x, sum;
  logic [pEXTR_W:0] sum_abs;
  extr_t            a_mag, lapri;
  state_t           state_q, state_d;
  bit_idx_t         cnt_q, cnt_d, idx, last;
  extr_t            min0_q, min0_d, min1_q, min1_d, u_min0, u_min1;
  bit_idx_t         min0_idx_q, min0_idx_d, u_idx;
  logic             sign_q, sign_d, u_sign, sof_q, sof_d, ptr_q, ptr_d, first;
  logic             write_q, write_d, wptr_q, wptr_d;
  bit_idx_t         waddr_q, waddr_d;
  extr_t            wdat_q, wdat_d;
  logic             oval_q, oval_d, optr_q, optr_d, oprod_q, oprod_d, oerr_q, oerr_d;
  strb_t            ostrb_q, ostrb_d;
  extr_t            omin0_q, omin0_d, omin1_q, omin1_d;
  bit_idx_t         omin0_idx_q, omin0_idx_d;

  // Lextr is sign-magnitude; the sum never overflows pEXTR_W+1 bits, so only the final clip saturates
  always_comb begin
    llr_x   = extr_p1_t'(signed'(iLLR));
    extr_x  = !iuse_extr ? '0 :
              iLextr[pEXTR_W-1] ? -extr_p1_t'({1'b0, iLextr[pEXTR_W-2:0]}) :
                                   extr_p1_t'({1'b0, iLextr[pEXTR_W-2:0]});
    sum     = llr_x + extr_x;
    sum_abs = sum[pEXTR_W] ? -sum : sum;
    a_mag   = (sum_abs > {1'b0, cEXTR_MAX}) ? cEXTR_MAX : extr_t'(sum_abs);
    lapri   = {sum[pEXTR_W], a_mag[pEXTR_W-2:0]};
  end

  btc_dec_spc_min2_update u_min2 (
    .ifirst    (first),
    .isign     (lapri[pEXTR_W-1]),
    .imag      (a_mag),
    .iidx      (idx),
    .imin0     (min0_q),
    .imin1     (min1_q),
    .imin0_idx (min0_idx_q),
    .isign_acc (sign_q),
    .omin0     (u_min0),
    .omin1     (u_min1),
    .omin0_idx (u_idx),
    .osign     (u_sign)
  );

  // a bit arriving outside a word is taken as an implicit start so the accumulators never hold stale data
  always_comb begin
    first       = istrb.sop | (state_q == IDLE);
    idx         = first ? '0 : cnt_q;
    last        = bit_idx_t'(get_code_bits(imode) - 1'b1);
    state_d     = state_q;
    cnt_d       = cnt_q;
    min0_d      = min0_q;
    min1_d      = min1_q;
    min0_idx_d  = min0_idx_q;
    sign_d      = sign_q;
    sof_d       = sof_q;
    ptr_d       = ptr_q;
    write_d     = 1'b0;
    wptr_d      = wptr_q;
    waddr_d     = waddr_q;
    wdat_d      = wdat_q;
    oval_d      = 1'b0;
    oerr_d      = 1'b0;
    optr_d      = optr_q;
    oprod_d     = oprod_q;
    ostrb_d     = ostrb_q;
    omin0_d     = omin0_q;
    omin1_d     = omin1_q;
    omin0_idx_d = omin0_idx_q;
    if (ival) begin
      write_d    = 1'b1;
      wptr_d     = ptr_q;
      waddr_d    = idx;
      wdat_d     = lapri;
      cnt_d      = idx + 1'b1;
      state_d    = istrb.eop ? IDLE : ACC;
      min0_d     = u_min0;
      min1_d     = u_min1;
      min0_idx_d = u_idx;
      sign_d     = u_sign;
      sof_d      = first ? istrb.sof : sof_q;
      oerr_d     = (istrb.sop == (state_q == ACC)) | (istrb.eop & (idx != last));
      if (istrb.eop) begin
        ptr_d       = ~ptr_q;
        oval_d      = 1'b1;
        optr_d      = ptr_q;
        oprod_d     = u_sign;
        omin0_d     = u_min0;
        omin1_d     = u_min1;
        omin0_idx_d = u_idx;
        ostrb_d     = '{sof: sof_d, sop: 1'b1, eop: 1'b1, eof: istrb.eof, mask: istrb.mask};
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      min0_q      <= '0;
      min1_q      <= '0;
      min0_idx_q  <= '0;
      sign_q      <= 1'b0;
      sof_q       <= 1'b0;
      ptr_q       <= 1'b0;
      write_q     <= 1'b0;
      wptr_q      <= 1'b0;
      waddr_q     <= '0;
      wdat_q      <= '0;
      oval_q      <= 1'b0;
      oerr_q      <= 1'b0;
      optr_q      <= 1'b0;
      oprod_q     <= 1'b0;
      ostrb_q     <= '0;
      omin0_q     <= '0;
      omin1_q     <= '0;
      omin0_idx_q <= '0;
    end else if (iclkena) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      min0_q      <= min0_d;
      min1_q      <= min1_d;
      min0_idx_q  <= min0_idx_d;
      sign_q      <= sign_d;
      sof_q       <= sof_d;
      ptr_q       <= ptr_d;
      write_q     <= write_d;
      wptr_q      <= wptr_d;
      waddr_q     <= waddr_d;
      wdat_q      <= wdat_d;
      oval_q      <= oval_d;
      oerr_q      <= oerr_d;
      optr_q      <= optr_d;
      oprod_q     <= oprod_d;
      ostrb_q     <= ostrb_d;
      omin0_q     <= omin0_d;
      omin1_q     <= omin1_d;
      omin0_idx_q <= omin0_idx_d;
    end
  end

  assign oLapri_write = write_q;
  assign oLapri_wptr  = wptr_q;
  assign oLapri_waddr = waddr_q;
  assign oLapri_wdat  = wdat_q;
  assign oval         = oval_q;
  assign ostrb        = ostrb_q;
  assign oLapri_ptr   = optr_q;
  assign oprod_sign   = oprod_q;
  assign omin0        = omin0_q;
  assign omin0_idx    = omin0_idx_q;
  assign omin1        = omin1_q;
  assign oerr         = oerr_q;
endmodule

// File: tb/tb_btc_dec_spc_sort.sv
// tb_btc_dec_spc_sort: vector table plus write/result scoreboards for the SPC sort stage
module tb_btc_dec_spc_sort;
  import btc_dec_spc_sort_pkg::*;

  typedef struct packed {
    logic [4:0] llr;
    logic [4:0] lx;
    logic       u;
    logic [4:0] w;
  } vec_t;
  typedef struct packed {
    bit_idx_t addr;
    extr_t    dat;
    logic     ptr;
  } wr_t;
  typedef struct packed {
    logic     ptr;
    logic     sign;
    extr_t    min0;
    bit_idx_t idx;
    extr_t    min1;
    strb_t    strb;
    logic     err;
  } res_t;

  logic           iclk = 1'b0, ireset, iclkena, ival, iuse_extr;
  btc_code_mode_t imode;
  strb_t          istrb;
  logic [4:0]     iLLR;
  extr_t          iLextr;
  logic           oLapri_write, oLapri_wptr, oval, oLapri_ptr, oprod_sign, oerr;
  bit_idx_t       oLapri_waddr, omin0_idx;
  extr_t          oLapri_wdat, omin0, omin1;
  strb_t          ostrb;
  logic           en_s;

  vec_t tab [16];
  wr_t  wq [$];
  res_t rq [$];
  int   checks = 0, passes = 0, err_only = 0, cnt = 0;
  logic wp = 1'b0, sof_in = 1'b1, eof_in = 1'b1, mask_in = 1'b0;

  btc_dec_spc_sort dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .imode(imode), .ival(ival), .istrb(istrb),
    .iLLR(iLLR), .iLextr(iLextr), .iuse_extr(iuse_extr), .oLapri_write(oLapri_write),
    .oLapri_wptr(oLapri_wptr), .oLapri_waddr(oLapri_waddr), .oLapri_wdat(oLapri_wdat), .oval(oval),
    .ostrb(ostrb), .oLapri_ptr(oLapri_ptr), .oprod_sign(oprod_sign), .omin0(omin0),
    .omin0_idx(omin0_idx), .omin1(omin1), .oerr(oerr)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) en_s <= iclkena;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] lapri_model(logic [4:0] llr, logic [4:0] lx, logic u);
    int s = int'(signed'(llr)) + (u ? (lx[4] ? -int'(lx[3:0]) : int'(lx[3:0])) : 0);
    if (s > 15) s = 15;
    if (s < -15) s = -15;
    return s < 0 ? {1'b1, 4'(-s)} : {1'b0, 4'(s)};
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic send(input logic [4:0] llr, input logic [4:0] lx, input logic u,
                      input logic sop, input logic eop, input logic [4:0] w, input logic gap);
    if (sop) cnt = 0;
    wq.push_back('{addr: bit_idx_t'(cnt), dat: w, ptr: wp});
    cnt++;
    if (eop) wp = ~wp;
    ival = 1'b1; iLLR = llr; iLextr = lx; iuse_extr = u;
    istrb = '{sof: sof_in, sop: sop, eop: eop, eof: eof_in, mask: mask_in};
    if (gap) begin
      iclkena = 1'b0;
      @(posedge iclk); #1;
      iclkena = 1'b1;
    end
    @(posedge iclk); #1;
  endtask

  task automatic idle(input int n);
    ival = 1'b0;
    istrb = '0;
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic exp_res(input logic p, input logic s, input extr_t m0, input bit_idx_t i,
                         input extr_t m1, input strb_t st, input logic e);
    rq.push_back('{ptr: p, sign: s, min0: m0, idx: i, min1: m1, strb: st, err: e});
  endtask

  task automatic word_tab(input int base, input logic gap);
    for (int i = 0; i < 8; i++)
      send(tab[base+i].llr, tab[base+i].lx, tab[base+i].u, i == 0, i == 7, tab[base+i].w, gap && i[0]);
  endtask

  initial begin
    logic [37:0] all_outs;
    int v [8];
    tab = '{
      '{5'h03, 5'h00, 1'b0, 5'h03}, '{5'h1B, 5'h00, 1'b0, 5'h15},
      '{5'h07, 5'h00, 1'b0, 5'h07}, '{5'h02, 5'h00, 1'b0, 5'h02},
      '{5'h1F, 5'h00, 1'b0, 5'h11}, '{5'h06, 5'h00, 1'b0, 5'h06},
      '{5'h04, 5'h00, 1'b0, 5'h04}, '{5'h09, 5'h00, 1'b0, 5'h09},
      '{5'h0F, 5'h0F, 1'b1, 5'h0F}, '{5'h10, 5'h1F, 1'b1, 5'h1F},
      '{5'h03, 5'h13, 1'b1, 5'h00}, '{5'h10, 5'h00, 1'b0, 5'h1F},
      '{5'h05, 5'h12, 1'b1, 5'h03}, '{5'h1C, 5'h03, 1'b1, 5'h11},
      '{5'h00, 5'h10, 1'b1, 5'h00}, '{5'h07, 5'h0A, 1'b0, 5'h07}
    };
    ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; imode = cCODE_8; istrb = '0;
    iLLR = '0; iLextr = '0; iuse_extr = 1'b0;
    fork
      forever begin
        @(negedge iclk);
        if (!ireset && en_s === 1'b1) begin
          if (oLapri_write) begin
            if (wq.size() == 0) chk("write_unexpected", 64'(oLapri_waddr), 64'hFFFF);
            else chk("lapri_write", 64'({oLapri_waddr, oLapri_wdat, oLapri_wptr}), 64'(wq.pop_front()));
          end
          if (oval) begin
            if (rq.size() == 0) chk("oval_unexpected", 64'(omin0), 64'hFFFF);
            else chk("result", 64'({oLapri_ptr, oprod_sign, omin0, omin0_idx, omin1, ostrb, oerr}),
                     64'(rq.pop_front()));
          end else if (oerr) err_only++;
        end
      end
    join_none
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    all_outs = {oLapri_write, oLapri_wptr, oLapri_waddr, oLapri_wdat, oval, ostrb, oLapri_ptr,
                oprod_sign, omin0, omin0_idx, omin1, oerr};
    chk("reset_outs", 64'(all_outs), 64'h0);
    @(posedge iclk); #1;
    ireset = 1'b0;
    // basic word then saturation word, back to back
    exp_res(1'b0, 1'b0, 5'd1, 6'd4, 5'd2, 5'b11110, 1'b0);
    word_tab(0, 1'b0);
    exp_res(1'b1, 1'b1, 5'd0, 6'd2, 5'd0, 5'b11110, 1'b0);
    word_tab(8, 1'b0);
    idle(2);
    // equal magnitudes, strobe mapping
    sof_in = 1'b0; eof_in = 1'b0; mask_in = 1'b1;
    exp_res(1'b0, 1'b0, 5'd4, 6'd0, 5'd4, 5'b01101, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [4:0] l;
      l = i[0] ? 5'h1C : 5'h04;
      send(l, 5'h00, 1'b0, i == 0, i == 7, lapri_model(l, 5'h00, 1'b0), 1'b0);
    end
    sof_in = 1'b1; eof_in = 1'b1; mask_in = 1'b0;
    idle(2);
    // reset, then two back-to-back words with pointer ping-pong
    ireset = 1'b1; @(posedge iclk); #1; ireset = 1'b0; wp = 1'b0;
    exp_res(1'b0, 1'b0, 5'd1, 6'd0, 5'd2, 5'b11110, 1'b0);
    exp_res(1'b1, 1'b1, 5'd0, 6'd7, 5'd1, 5'b11110, 1'b0);
    for (int i = 0; i < 8; i++) send(5'(i + 1), 5'h00, 1'b0, i == 0, i == 7, lapri_model(5'(i + 1), 5'h00, 1'b0), 1'b0);
    for (int i = 0; i < 8; i++) send(5'(i - 8), 5'h01, 1'b1, i == 0, i == 7, lapri_model(5'(i - 8), 5'h01, 1'b1), 1'b0);
    idle(2);
    // partial word dropped by an early sop, then a short word
    for (int i = 0; i < 5; i++) send(5'd5, 5'h00, 1'b0, i == 0, 1'b0, 5'd5, 1'b0);
    v = '{6, -2, 5, 3, -7, 2, 4, -1};
    exp_res(1'b0, 1'b1, 5'd1, 6'd7, 5'd2, 5'b11110, 1'b0);
    for (int i = 0; i < 8; i++) send(5'(v[i]), 5'h00, 1'b0, i == 0, i == 7, lapri_model(5'(v[i]), 5'h00, 1'b0), 1'b0);
    exp_res(1'b1, 1'b0, 5'd1, 6'd0, 5'd2, 5'b11110, 1'b1);
    for (int i = 0; i < 6; i++) send(5'(i + 1), 5'h00, 1'b0, i == 0, i == 5, 5'(i + 1), 1'b0);
    idle(3);
    chk("err_only_after_drop", 64'(err_only), 64'd1);
    // clock-enable gaps mid-word
    exp_res(1'b0, 1'b0, 5'd1, 6'd4, 5'd2, 5'b11110, 1'b0);
    word_tab(0, 1'b1);
    idle(2);
    // async reset mid-word
    for (int i = 0; i < 3; i++) send(tab[i].llr, 5'h00, 1'b0, i == 0, 1'b0, tab[i].w, 1'b0);
    idle(1);
    ireset = 1'b1;
    @(negedge iclk);
    all_outs = {oLapri_write, oLapri_wptr, oLapri_waddr, oLapri_wdat, oval, ostrb, oLapri_ptr,
                oprod_sign, omin0, omin0_idx, omin1, oerr};
    chk("reset_mid_outs", 64'(all_outs), 64'h0);
    @(posedge iclk); #1;
    ireset = 1'b0; wp = 1'b0;
    exp_res(1'b0, 1'b0, 5'd1, 6'd4, 5'd2, 5'b11110, 1'b0);
    word_tab(0, 1'b0);
    idle(3);
    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    chk("result_queue_drained", 64'(rq.size()), 64'd0);
    chk("err_only_final", 64'(err_only), 64'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
